// File: rtl/demux32bit1to4.sv
// ---------------------------------------------------------------------------
// demux32bit1to4 -- buffered 1-to-4 demultiplexer for 32-bit words.
//
// A single producer offers {in_data, in_sel} over a valid/ready handshake.
// Words are held in a 2-entry FIFO and presented, in strict arrival order,
// on the one output channel (A..D) named by their select value.
//
// Handshake semantics (both sides): a transfer happens on a rising Clk edge
// exactly when valid and ready are both high at that edge. A valid, once
// raised, is held with stable payload until the transfer completes.
//
// Parameters:
//   DEPTH  buffer entries (fixed at 2)
//   CNT_W  width of deliver_cnt (only meaningful with DEMUX32_DELIVER_CNT_EN)
//
// Ports:
//   Clk          rising-edge clock
//   Rst_n        asynchronous active-low reset
//   in_data      word to route
//   in_sel       destination: 0=A, 1=B, 2=C, 3=D
//   in_valid     producer offers a word
//   in_ready     buffer has space (depends only on registered state)
//   outA..outD   head-entry data on every channel (0 when empty)
//   out_valid    one-hot: bit i set when channel i holds the head word
//   out_ready    per-channel consumer accept; non-selected bits ignored
//   deliver_cnt  count of delivered words, wraps (macro builds only)
//   state_dbg    occupancy state: 0=EMPTY, 1=ONE, 2=TWO
//
// Optional feature macro: DEMUX32_DELIVER_CNT_EN adds deliver_cnt.
// ---------------------------------------------------------------------------
module demux32bit1to4 #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [31:0]      in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      outA,
  output logic [31:0]      outB,
  output logic [31:0]      outC,
  output logic [31:0]      outD,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
`ifdef DEMUX32_DELIVER_CNT_EN
  output logic [CNT_W-1:0] deliver_cnt,
`endif
  output logic [1:0]       state_dbg
);

  // Pointers are one bit wide, so only a two-entry buffer is meaningful.
  if (DEPTH != 2 || CNT_W < 1) begin : g_bad_cfg
    $error("demux32bit1to4: DEPTH must be 2 and CNT_W at least 1");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] mem_data [DEPTH];
  logic [1:0]  mem_sel  [DEPTH];
  logic        rd_ptr;
  logic        wr_ptr;

  logic        push;
  logic        pop;
  logic [31:0] head_data;
  logic [1:0]  head_sel;

  assign head_data = mem_data[rd_ptr];
  assign head_sel  = mem_sel[rd_ptr];

  // Outputs are decoded purely from registered state.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 4'b0000;
    outA      = 32'h0;
    outB      = 32'h0;
    outC      = 32'h0;
    outD      = 32'h0;
    if (state == TWO) begin
      in_ready = 1'b0;
    end
    if (state != EMPTY) begin
      out_valid = 4'b0001 << head_sel;
      outA      = head_data;
      outB      = head_data;
      outC      = head_data;
      outD      = head_data;
    end
  end

  assign push      = in_valid & in_ready;
  // Only the ready bit of the head's own channel can complete a pop.
  assign pop       = |(out_valid & out_ready);
  assign state_dbg = state;

  // Occupancy next-state.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = TWO;
        else if (!push && pop) state_nxt = EMPTY;
        else                   state_nxt = ONE;
      end
      TWO:     if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state  <= EMPTY;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= 32'h0;
        mem_sel[i]  <= 2'd0;
      end
    end else begin
      state <= state_nxt;
      if (push) begin
        mem_data[wr_ptr] <= in_data;
        mem_sel[wr_ptr]  <= in_sel;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

`ifdef DEMUX32_DELIVER_CNT_EN
  // One increment per delivered word; natural wrap at 2^CNT_W.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      deliver_cnt <= '0;
    end else if (pop) begin
      deliver_cnt <= deliver_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_demux32bit1to4.sv
// ---------------------------------------------------------------------------
// tb_demux32bit1to4 -- directed self-checking bench for demux32bit1to4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_demux32bit1to4;

`ifdef DEMUX32_DELIVER_CNT_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  logic             Clk;
  logic             Rst_n;
  logic [31:0]      in_data;
  logic [1:0]       in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      outA, outB, outC, outD;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [1:0]       state_dbg;
`ifdef DEMUX32_DELIVER_CNT_EN
  logic [CNT_W-1:0] deliver_cnt;
`endif

  int tests_run = 0;
  int fail_cnt  = 0;

  demux32bit1to4 #(.DEPTH(2), .CNT_W(CNT_W)) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .in_data     (in_data),
    .in_sel      (in_sel),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .outA        (outA),
    .outB        (outB),
    .outC        (outC),
    .outD        (outD),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
`ifdef DEMUX32_DELIVER_CNT_EN
    .deliver_cnt (deliver_cnt),
`endif
    .state_dbg   (state_dbg)
  );

  // clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // checking
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_push(input logic [31:0] d, input logic [1:0] s);
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
  endtask

  task automatic drive_idle();
    in_valid = 1'b0;
    in_data  = 32'h0;
    in_sel   = 2'd0;
  endtask

  logic [3:0]  exp_oh;
  logic [31:0] exp_d;

  initial begin
    // reset
    Rst_n     = 1'b0;
    out_ready = 4'b0000;
    drive_idle();
    #3;
    check_eq("rst_out_valid", {28'h0, out_valid}, 32'h0);
    check_eq("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check_eq("rst_outA", outA, 32'h0);
    step();
    step();
    Rst_n = 1'b1;

    // single word to channel C
    drive_push(32'hDEADBEEF, 2'd2);
    step();
    drive_idle();
    check_eq("single_out_valid", {28'h0, out_valid}, 32'h4);
    check_eq("single_outC", outC, 32'hDEADBEEF);
    check_eq("single_in_ready", {31'h0, in_ready}, 32'h1);
    out_ready = 4'b0100;
    step();
    out_ready = 4'b0000;
    check_eq("single_popped", {28'h0, out_valid}, 32'h0);
`ifdef DEMUX32_DELIVER_CNT_EN
    check_eq("single_cnt", {28'h0, deliver_cnt}, 32'd1);
`endif

    // fill and backpressure
    drive_push(32'h11111111, 2'd0);
    step();
    drive_push(32'h33333333, 2'd3);
    step();
    check_eq("full_in_ready", {31'h0, in_ready}, 32'h0);
    check_eq("full_out_valid", {28'h0, out_valid}, 32'h1);
    check_eq("full_outA", outA, 32'h11111111);
    drive_push(32'h55555555, 2'd1);
    step();
    drive_idle();
    check_eq("third_rejected_ready", {31'h0, in_ready}, 32'h0);
    check_eq("third_rejected_head", outA, 32'h11111111);
    out_ready = 4'b1111;
    step();
    check_eq("drain_out_valid_D", {28'h0, out_valid}, 32'h8);
    check_eq("drain_outD", outD, 32'h33333333);
    check_eq("drain_in_ready", {31'h0, in_ready}, 32'h1);
    step();
    check_eq("drain_empty", {28'h0, out_valid}, 32'h0);
    out_ready = 4'b0000;

    // wrong-channel ready does not pop
    drive_push(32'h22222222, 2'd1);
    step();
    drive_idle();
    out_ready = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq($sformatf("wrong_ch_hold%0d", i), {28'h0, out_valid}, 32'h2);
    end
    check_eq("wrong_ch_outB", outB, 32'h22222222);
    out_ready = 4'b0010;
    step();
    check_eq("right_ch_pop", {28'h0, out_valid}, 32'h0);

    // streaming 8 words, one delivery per cycle
    out_ready = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      drive_push(32'hA0000000 + i, 2'(i % 4));
      check_eq($sformatf("stream_in_ready%0d", i), {31'h0, in_ready}, 32'h1);
      step();
      exp_oh = 4'b0001 << (i % 4);
      exp_d  = 32'hA0000000 + i;
      check_eq($sformatf("stream_valid%0d", i), {28'h0, out_valid}, {28'h0, exp_oh});
      check_eq($sformatf("stream_data%0d", i), outB, exp_d);
    end
    drive_idle();
    step();
    check_eq("stream_done", {28'h0, out_valid}, 32'h0);
`ifdef DEMUX32_DELIVER_CNT_EN
    check_eq("stream_cnt", {28'h0, deliver_cnt}, 32'd12);
`endif

    // async reset while full
    out_ready = 4'b0000;
    drive_push(32'h77777777, 2'd0);
    step();
    drive_push(32'h88888888, 2'd1);
    step();
    drive_idle();
    check_eq("pre_rst_full", {31'h0, in_ready}, 32'h0);
    #2;
    Rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", {28'h0, out_valid}, 32'h0);
    check_eq("arst_in_ready", {31'h0, in_ready}, 32'h1);
    check_eq("arst_outs", outA | outB | outC | outD, 32'h0);
    step();
    Rst_n = 1'b1;
    out_ready = 4'b1111;
    step();
    check_eq("post_rst_no_stale", {28'h0, out_valid}, 32'h0);
    check_eq("post_rst_state", {30'h0, state_dbg}, 32'h0);

`ifdef DEMUX32_DELIVER_CNT_EN
    // counter wrap: 17 deliveries with a 4-bit counter
    check_eq("wrap_start", {28'h0, deliver_cnt}, 32'd0);
    for (int i = 0; i < 17; i++) begin
      drive_push(32'hC0000000 + i, 2'(i % 4));
      step();
    end
    drive_idle();
    step();
    check_eq("wrap_cnt", {28'h0, deliver_cnt}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
